draw_span: RTL

//  Parametrised span rasteriser, successor to the fixed vertical-line drawer.

---
 rtl/draw_pkg.sv | 15 +
 rtl/span_counter.sv | 38 +++
 rtl/draw_span.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// draw_pkg: shared definitions for the span rasteriser.
//   ORIENT_VERT / ORIENT_HORIZ : values of the orient input
//   state_t                    : FSM encoding (IDLE, RUN, DONE)
package draw_pkg;

    localparam logic ORIENT_VERT  = 1'b0;
    localparam logic ORIENT_HORIZ = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/span_counter.sv
// span_counter: stepped-coordinate counter for draw_span.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : cur <= lo (takes priority over step)
//   step         : cur <= cur + 1
//   lo           : start coordinate
//   hi           : last coordinate of the span (held stable by the caller)
//   cur          : current coordinate
//   last         : cur == hi
module span_counter #(
    parameter int X_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] lo,
    input  logic [X_W-1:0] hi,
    output logic [X_W-1:0] cur,
    output logic           last
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples its inputs as they were before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur <= '0;
        end else if (load) begin
            cur <= lo;
        end else if (step) begin
            cur <= cur + 1'b1;
        end
    end

    // Termination is decided on equality before incrementing, so a span
    // ending at the all-ones coordinate never wraps.
    assign last = (cur == hi);

endmodule

// File: rtl/draw_span.sv
// draw_span: draws one vertical or horizontal run of pixels, lo..hi
// inclusive, into the VGA adapter at up to one pixel per clock.
//
// Optional feature: define DRAW_SPAN_GRADIENT_EN to add the colour_step
// port; the pixel colour then advances by colour_step on every transfer.
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : span request, sampled only in IDLE
//   orient       : 0 vertical (x fixed, y steps), 1 horizontal (y fixed, x steps)
//   fixed        : fixed coordinate (horizontal uses the low Y_W bits)
//   lo, hi       : first/last stepped coordinate (vertical uses the low Y_W bits)
//   colour       : base colour
//   colour_step  : per-pixel colour increment (DRAW_SPAN_GRADIENT_EN only)
//   busy         : span in progress (RUN and DONE)
//   done         : one-cycle completion pulse
//   vga_x, vga_y, vga_colour, vga_write : pixel to the adapter
//   vga_ready    : adapter accepts the pixel this cycle
module draw_span
    import draw_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 18
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                orient,
    input  logic [X_W-1:0]      fixed,
    input  logic [X_W-1:0]      lo,
    input  logic [X_W-1:0]      hi,
    input  logic [COLOUR_W-1:0] colour,
`ifdef DRAW_SPAN_GRADIENT_EN
    input  logic [COLOUR_W-1:0] colour_step,
`endif
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_write,
    input  logic                vga_ready
);

    // Keeps only the coordinate bits that are meaningful for a vertical span.
    localparam logic [X_W-1:0] Y_MASK = X_W'((1 << Y_W) - 1);

    state_t                state, state_next;
    logic                  orient_r;
    logic [X_W-1:0]        fixed_r;
    logic [X_W-1:0]        hi_r;
    logic                  empty_r;
    logic [COLOUR_W-1:0]   colour_r;
`ifdef DRAW_SPAN_GRADIENT_EN
    logic [COLOUR_W-1:0]   step_r;
`endif

    logic                  load;
    logic                  step;
    logic                  transfer;
    logic                  last;
    logic [X_W-1:0]        cur;
    logic [X_W-1:0]        lo_m;
    logic [X_W-1:0]        hi_m;

    // Reduce lo/hi to the active width up front; from then on the counter
    // and the empty check can work at full X_W without caring about orient.
    assign lo_m = (orient == ORIENT_HORIZ) ? lo : (lo & Y_MASK);
    assign hi_m = (orient == ORIENT_HORIZ) ? hi : (hi & Y_MASK);

    span_counter #(
        .X_W (X_W)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .step  (step),
        .lo    (lo_m),
        .hi    (hi_r),
        .cur   (cur),
        .last  (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        vga_write  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // The empty check runs on the latched operands, so an empty
                // span spends one silent RUN cycle before DONE.
                if (empty_r) begin
                    state_next = DONE;
                end else begin
                    vga_write = 1'b1;
                    if (vga_ready) begin
                        if (last) begin
                            state_next = DONE;
                        end else begin
                            step = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign transfer = vga_write && vga_ready;

    // Span operands are captured once at start; input changes while the
    // span runs have no effect.
    always_ff @(posedge clock) begin
        if (reset) begin
            orient_r <= ORIENT_VERT;
            fixed_r  <= '0;
            hi_r     <= '0;
            empty_r  <= 1'b0;
            colour_r <= '0;
`ifdef DRAW_SPAN_GRADIENT_EN
            step_r   <= '0;
`endif
        end else if (load) begin
            orient_r <= orient;
            fixed_r  <= fixed;
            hi_r     <= hi_m;
            empty_r  <= (lo_m > hi_m);
            colour_r <= colour;
`ifdef DRAW_SPAN_GRADIENT_EN
            step_r   <= colour_step;
        end else if (transfer) begin
            colour_r <= colour_r + step_r;
`endif
        end
    end

    assign vga_x      = (orient_r == ORIENT_HORIZ) ? cur : fixed_r;
    assign vga_y      = (orient_r == ORIENT_HORIZ) ? fixed_r[Y_W-1:0] : cur[Y_W-1:0];
    assign vga_colour = colour_r;

endmodule
